// File: rtl/pri_decoder8_hold.sv
// Hold-window decoder for the pri_encoder8 code/gs interface: each accepted code
// lights one of eight lines for HOLD_CYCLES clocks. Define ACTIVE_LOW_OUT_EN for inverted y.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no line held; y released, ready whenever ei=1
// HOLD  | one line held; cnt counts down to 0, ready again only at cnt==0
module pri_decoder8_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ei,
    input  logic [2:0] code,
    input  logic       gs_in,
    output logic       in_ready,
    output logic [7:0] y,
    output logic [2:0] idx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    onehot, onehot_nx;
    logic [2:0]    idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          done_nx;
    logic          last;
    logic          accept;

    assign last     = (state == HOLD) && (cnt == '0);
    assign in_ready = ei & ((state == IDLE) | last);
    assign accept   = ei & gs_in & in_ready;
    assign busy     = (state == HOLD);

    always_comb begin
        state_nx  = state;
        onehot_nx = onehot;
        idx_nx    = idx;
        cnt_nx    = cnt;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx  = HOLD;
                    onehot_nx = 8'b1 << code;
                    idx_nx    = code;
                    cnt_nx    = RELOAD;
                end else begin
                    onehot_nx = 8'h00;
                end
            end
            HOLD: begin
                if (!ei) begin
                    // abort: release immediately, no completion pulse
                    state_nx  = IDLE;
                    onehot_nx = 8'h00;
                    cnt_nx    = '0;
                end else if (last) begin
                    done_nx = 1'b1;
                    if (accept) begin
                        onehot_nx = 8'b1 << code;
                        idx_nx    = code;
                        cnt_nx    = RELOAD;
                    end else begin
                        state_nx  = IDLE;
                        onehot_nx = 8'h00;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx  = IDLE;
                onehot_nx = 8'h00;
                cnt_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            onehot <= 8'h00;
            idx    <= 3'd0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            onehot <= onehot_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            done   <= done_nx;
        end
    end

`ifdef ACTIVE_LOW_OUT_EN
    assign y = ~onehot;
`else
    assign y = onehot;
`endif

endmodule
